// File: rtl/serial_loader_if.sv
// Boot-loader signal bundle: serial input, RAM write port and core-release status.
// master = loader side, slave = surrounding system / bench side.
interface serial_loader_if;
  logic        rxd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        hold;
  logic        done;
  logic        error;

  modport master (
    input  rxd,
    output mem_we, mem_addr, mem_data, hold, done, error
  );

  modport slave (
    output rxd,
    input  mem_we, mem_addr, mem_data, hold, done, error
  );
endinterface

// File: rtl/serial_loader.sv
// Boot-time program loader: receives an 8N1 framed image, writes it to RAM word by word
// and keeps the core held in reset until the image checksum has been verified.
//
// Loader FSM states:
//   state  | meaning
//   S_IDLE | waiting for magic byte 0xA5
//   S_LEN0 | expecting word count, low byte
//   S_LEN1 | expecting word count, high byte; range-checked here
//   S_DATA | assembling data words and writing them to RAM
//   S_CSUM | expecting XOR checksum of all data bytes
//   S_DONE | image verified, core released; everything ignored until reset
//   S_ERR  | framing/length/checksum failure; only 0xA5 restarts a frame
module serial_loader #(
  parameter int BAUD_DIV  = 217,
  parameter int MAX_WORDS = 1024
) (
  input  logic            clk,
  input  logic            reset,
  serial_loader_if.master bus
);

  localparam int            CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [16:0]   MAX_N   = 17'(MAX_WORDS);
  localparam logic [7:0]    MAGIC   = 8'hA5;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RX_WAIT,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state, rx_state_nxt;
  logic          rxd_s1, rxd_s2;
  logic [CW-1:0] tmr, tmr_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          rx_valid, rx_valid_nxt;
  logic          rx_ferr;
  logic          tick;

  // Synchronizer clears to 0 so a line still low after reset keeps the receiver in RX_WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_s1   <= 1'b0;
      rxd_s2   <= 1'b0;
      rx_state <= RX_WAIT;
      tmr      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rxd_s1   <= bus.rxd;
      rxd_s2   <= rxd_s1;
      rx_state <= rx_state_nxt;
      tmr      <= tmr_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      rx_valid <= rx_valid_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    tmr_nxt      = tmr;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    rx_valid_nxt = 1'b0;
    rx_ferr      = 1'b0;
    tick         = (tmr == '0);
    case (rx_state)
      RX_WAIT: begin
        if (rxd_s2) rx_state_nxt = RX_IDLE;
      end
      RX_IDLE: begin
        if (!rxd_s2) begin
          rx_state_nxt = RX_START;
          tmr_nxt      = HALF_M1;
        end
      end
      RX_START: begin
        if (!tick) begin
          tmr_nxt = tmr - 1'b1;
        end else if (rxd_s2) begin
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_state_nxt = RX_DATA;
          tmr_nxt      = FULL_M1;
          bit_idx_nxt  = '0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          tmr_nxt = tmr - 1'b1;
        end else begin
          shift_nxt = {rxd_s2, shift[7:1]};
          tmr_nxt   = FULL_M1;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
          else                 bit_idx_nxt  = bit_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (!tick) begin
          tmr_nxt = tmr - 1'b1;
        end else if (rxd_s2) begin
          // Stop bit already seen high, so rearming needs no extra wait.
          rx_valid_nxt = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_ferr      = 1'b1;
          rx_state_nxt = RX_WAIT;
        end
      end
      default: rx_state_nxt = RX_WAIT;
    endcase
  end

  // ------------------------------------------------------------ loader FSM
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  len_lo, len_lo_nxt;
  logic [15:0] n_words, n_words_nxt;
  logic [15:0] idx, idx_nxt;
  logic [1:0]  pos, pos_nxt;
  logic [23:0] word, word_nxt;
  logic [7:0]  csum, csum_nxt;
  logic        we_q, we_nxt;
  logic [31:0] addr_q, addr_nxt;
  logic [31:0] data_q, data_nxt;
  logic        hold_q, hold_nxt;
  logic        done_q, done_nxt;
  logic        error_q, error_nxt;
  logic [15:0] len_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      len_lo  <= '0;
      n_words <= '0;
      idx     <= '0;
      pos     <= '0;
      word    <= '0;
      csum    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_lo  <= len_lo_nxt;
      n_words <= n_words_nxt;
      idx     <= idx_nxt;
      pos     <= pos_nxt;
      word    <= word_nxt;
      csum    <= csum_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      hold_q  <= hold_nxt;
      done_q  <= done_nxt;
      error_q <= error_nxt;
    end
  end

  assign len_full = {shift, len_lo};

  always_comb begin
    state_nxt   = state;
    len_lo_nxt  = len_lo;
    n_words_nxt = n_words;
    idx_nxt     = idx;
    pos_nxt     = pos;
    word_nxt    = word;
    csum_nxt    = csum;
    we_nxt      = 1'b0;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    hold_nxt    = hold_q;
    done_nxt    = done_q;
    error_nxt   = error_q;
    // A framing error flags one cycle after the stop sample, ahead of normal byte delivery.
    if (rx_ferr) begin
      if (state != S_DONE) begin
        state_nxt = S_ERR;
        error_nxt = 1'b1;
        hold_nxt  = 1'b1;
      end
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (shift == MAGIC) state_nxt = S_LEN0;
        end
        S_LEN0: begin
          len_lo_nxt = shift;
          state_nxt  = S_LEN1;
        end
        S_LEN1: begin
          n_words_nxt = len_full;
          if (len_full == 16'd0 || {1'b0, len_full} > MAX_N) begin
            state_nxt = S_ERR;
            error_nxt = 1'b1;
          end else begin
            idx_nxt   = '0;
            csum_nxt  = '0;
            pos_nxt   = '0;
            state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          csum_nxt = csum ^ shift;
          word_nxt = {shift, word[23:8]};
          pos_nxt  = pos + 1'b1;
          if (pos == 2'd3) begin
            we_nxt   = 1'b1;
            addr_nxt = {16'd0, idx};
            data_nxt = {shift, word};
            idx_nxt  = idx + 16'd1;
            if (idx == n_words - 16'd1) state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (shift == csum) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            hold_nxt  = 1'b0;
          end else begin
            state_nxt = S_ERR;
            error_nxt = 1'b1;
          end
        end
        S_ERR: begin
          if (shift == MAGIC) begin
            state_nxt = S_LEN0;
            error_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.hold     = hold_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: byte-level frame model predicts every RAM write and status change
// and the exact cycle it must appear; directed scenarios plus randomized frames.
`timescale 1ns/1ps
module tb_serial_loader;
  localparam int B        = 4;
  localparam int HALF     = B / 2;
  localparam int MAXW     = 1024;
  // Cycles from driving a start bit to the byte's effect on the outputs.
  localparam int LAT_BYTE = 4 + HALF + 9 * B;
  localparam int LAT_FERR = 3 + HALF + 9 * B;

  localparam int EV_WR   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_CLR  = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  serial_loader_if bus ();

  serial_loader #(.BAUD_DIV(B), .MAX_WORDS(MAXW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t         evq[$];
  logic [7:0]  frame[$];
  bit          m_loaded;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  logic        exp_we, exp_done, exp_hold, exp_err;
  logic [31:0] exp_addr, exp_data;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
  endfunction

  function automatic void push_ev(int c, int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.data = d;
    evq.push_back(e);
  endfunction

  function automatic void model_clear();
    evq.delete();
    frame.delete();
    m_loaded = 1'b0;
  endfunction

  // Interpret the frame by byte position since the magic byte.
  function automatic void model_byte(logic [7:0] b, int eff);
    int          p, n;
    logic [7:0]  x;
    logic [31:0] w;
    if (m_loaded) return;
    if (frame.size() == 0) begin
      if (b == 8'hA5) begin
        frame.push_back(b);
        push_ev(eff, EV_CLR, 0, 0);
      end
      return;
    end
    frame.push_back(b);
    p = frame.size() - 1;
    if (p < 2) return;
    n = int'(frame[1]) + 256 * int'(frame[2]);
    if (p == 2) begin
      if (n == 0 || n > MAXW) begin
        push_ev(eff, EV_ERR, 0, 0);
        frame.delete();
      end
      return;
    end
    if (p < 3 + 4 * n) begin
      if ((p - 3) % 4 == 3) begin
        w = {frame[p], frame[p-1], frame[p-2], frame[p-3]};
        push_ev(eff, EV_WR, 32'((p - 3) / 4), w);
      end
      return;
    end
    x = 8'h00;
    for (int i = 3; i < p; i++) x = x ^ frame[i];
    if (x == b) begin
      push_ev(eff, EV_DONE, 0, 0);
      m_loaded = 1'b1;
    end else begin
      push_ev(eff, EV_ERR, 0, 0);
    end
    frame.delete();
  endfunction

  function automatic void model_ferr(int eff);
    if (m_loaded) return;
    push_ev(eff, EV_ERR, 0, 0);
    frame.delete();
  endfunction

  // Single compare process: every cycle, all outputs against the model's timeline.
  always @(negedge clk) begin
    if (reset) begin
      exp_we = 1'b0; exp_addr = '0; exp_data = '0;
      exp_done = 1'b0; exp_hold = 1'b1; exp_err = 1'b0;
    end else begin
      exp_we = 1'b0;
      while (evq.size() > 0 && evq[0].cyc <= cyc) begin
        case (evq[0].kind)
          EV_WR:   begin exp_we = 1'b1; exp_addr = evq[0].addr; exp_data = evq[0].data; end
          EV_DONE: begin exp_done = 1'b1; exp_hold = 1'b0; exp_err = 1'b0; end
          EV_ERR:  begin exp_err = 1'b1; exp_hold = 1'b1; exp_done = 1'b0; end
          default: exp_err = 1'b0;
        endcase
        void'(evq.pop_front());
      end
    end
    chk("mem_we",   32'(bus.mem_we), 32'(exp_we));
    chk("mem_addr", bus.mem_addr,    exp_addr);
    chk("mem_data", bus.mem_data,    exp_data);
    chk("done",     32'(bus.done),   32'(exp_done));
    chk("hold",     32'(bus.hold),   32'(exp_hold));
    chk("error",    32'(bus.error),  32'(exp_err));
    if (bus.mem_we === 1'b1) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_data);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    int         c0;
    logic [9:0] bits;
    step(gap);
    c0 = cyc;
    if (stop_ok) model_byte(b, c0 + LAT_BYTE);
    else         model_ferr(c0 + LAT_FERR);
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rxd = bits[i];
      step(B);
    end
    bus.rxd = 1'b1;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int max_gap);
    foreach (q[i]) send_byte(q[i], 1'b1, $urandom_range(0, max_gap));
  endtask

  task automatic chk_now_reset(input string tag);
    chk({tag, "_hold"},  32'(bus.hold),   32'd1);
    chk({tag, "_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_done"},  32'(bus.done),   32'd0);
    chk({tag, "_error"}, 32'(bus.error),  32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk_now_reset("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(4);
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic chk_log(input int i, input logic [31:0] a, input logic [31:0] d);
    if (log_addr.size() > i) begin
      chk($sformatf("w%0d_addr", i), log_addr[i], a);
      chk($sformatf("w%0d_data", i), log_data[i], d);
    end else begin
      chk($sformatf("w%0d_present", i), 32'(log_addr.size()), 32'(i + 1));
    end
  endtask

  task automatic chk_status(input string tag, input logic d, input logic h, input logic e);
    chk({tag, "_done"},  32'(bus.done),  32'(d));
    chk({tag, "_hold"},  32'(bus.hold),  32'(h));
    chk({tag, "_error"}, 32'(bus.error), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  one_word[$];
    logic [31:0] w;
    logic [7:0]  x, jb;
    int          n;

    reset   = 1'b1;
    bus.rxd = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    step(4);
    one_word = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};

    // Single word
    do_reset();
    send_seq(one_word, 0);
    step(50);
    chk("single_writes", 32'(log_addr.size()), 32'd1);
    chk_log(0, 32'd0, 32'h12345678);
    chk_status("single", 1'b1, 1'b0, 1'b0);

    // Two words back-to-back, then trailing bytes that must be ignored
    do_reset();
    q = '{8'hA5, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
          8'h01, 8'h00, 8'h00, 8'h00, 8'h23, 8'hA5, 8'h01};
    send_seq(q, 0);
    step(50);
    chk("two_writes", 32'(log_addr.size()), 32'd2);
    chk_log(0, 32'd0, 32'hDEADBEEF);
    chk_log(1, 32'd1, 32'h00000001);
    chk_status("two", 1'b1, 1'b0, 1'b0);

    // Bad checksum, then recovery without reset
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_seq(q, 1);
    step(50);
    chk("badsum_writes", 32'(log_addr.size()), 32'd1);
    chk_log(0, 32'd0, 32'h12345678);
    chk_status("badsum", 1'b0, 1'b1, 1'b1);
    send_seq(one_word, 1);
    step(50);
    chk_log(1, 32'd0, 32'h12345678);
    chk_status("recover", 1'b1, 1'b0, 1'b0);

    // Length 0, then length 0x0401
    do_reset();
    q = '{8'hA5, 8'h00, 8'h00};
    send_seq(q, 0);
    step(50);
    chk("len0_writes", 32'(log_addr.size()), 32'd0);
    chk_status("len0", 1'b0, 1'b1, 1'b1);
    q = '{8'hA5, 8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(q, 0);
    step(50);
    chk("lenbig_writes", 32'(log_addr.size()), 32'd0);
    chk_status("lenbig", 1'b0, 1'b1, 1'b1);

    // Framing error mid-header, then a valid frame
    do_reset();
    send_byte(8'hA5, 1'b1, 0);
    send_byte(8'h3C, 1'b0, 0);
    step(50);
    chk_status("frame", 1'b0, 1'b1, 1'b1);
    send_seq(one_word, 2);
    step(50);
    chk_log(0, 32'd0, 32'h12345678);

    // Glitches in idle and inside a frame header; junk before the magic byte
    do_reset();
    bus.rxd = 1'b0; step(1); bus.rxd = 1'b1; step(50);
    q = '{8'h00, 8'hFF, 8'hA5};
    send_seq(q, 2);
    step(2);
    bus.rxd = 1'b0; step(1); bus.rxd = 1'b1; step(50);
    q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_seq(q, 2);
    step(50);
    chk("glitch_writes", 32'(log_addr.size()), 32'd1);
    chk_log(0, 32'd0, 32'h12345678);
    chk_status("glitch", 1'b1, 1'b0, 1'b0);

    // Reset during the third data byte (0x00), released while rxd is still low
    do_reset();
    q = '{8'hA5, 8'h01, 8'h00, 8'h56, 8'h34};
    send_seq(q, 0);
    bus.rxd = 1'b0;
    step(3 * B);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    chk_now_reset("midrst");
    step(2);
    reset = 1'b0;
    step(6 * B - 2);
    bus.rxd = 1'b1;
    step(B + 10);
    log_addr.delete();
    log_data.delete();
    send_seq(one_word, 0);
    step(50);
    chk("midrst_writes", 32'(log_addr.size()), 32'd1);
    chk_log(0, 32'd0, 32'h12345678);
    chk_status("midrst", 1'b1, 1'b0, 1'b0);

    // Randomized frames with junk, gaps, occasional bad checksum and trailing bytes
    for (int it = 0; it < 8; it++) begin
      do_reset();
      q.delete();
      repeat ($urandom_range(0, 2)) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'hA5) jb = 8'h5A;
        q.push_back(jb);
      end
      n = $urandom_range(1, 4);
      q.push_back(8'hA5);
      q.push_back(8'(n));
      q.push_back(8'h00);
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = $urandom();
        for (int j = 0; j < 4; j++) begin
          q.push_back(w[8*j +: 8]);
          x = x ^ w[8*j +: 8];
        end
      end
      if ($urandom_range(0, 3) == 0) x = x ^ 8'h40;
      q.push_back(x);
      q.push_back(8'($urandom_range(0, 255)));
      q.push_back(8'hA5);
      send_seq(q, 2);
      step(50);
    end

    chk("events_drained", 32'(evq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
# serial_loader

Boot-time program loader sitting directly upstream of the core and its program/data block RAM. Receives a framed 8N1 serial image on `rxd` and writes it word by word into RAM through a dedicated write port. Holds the core in reset via `hold` until a complete, checksum-valid image has been written, then releases it.

## Interface

Parameters:
- `BAUD_DIV`, default 217: clocks per serial bit (25 MHz / 115200); minimum 4.
- `MAX_WORDS`, default 1024: largest accepted image in 32-bit words; matches RAM depth.

Ports:
- `clk  in  1`: single clock; all logic is on its rising edge.
- `reset  in  1`: asynchronous, active-high; clears every register.
- `rxd  in  1`: serial input, idle high, asynchronous to `clk`.
- `mem_we  out  1`: one-cycle write strobe to RAM port A.
- `mem_addr  out  32`: word address of the current write.
- `mem_data  out  32`: word being written.
- `hold  out  1`: high keeps the core in reset; top ANDs `~hold` into the core's `reset_n`.
- `done  out  1`: image loaded and verified.
- `error  out  1`: framing, length or checksum failure.

## Operation

- Reset values: `mem_we`=0, `mem_addr`=0, `mem_data`=0, `hold`=1, `done`=0, `error`=0.
- Receiver:
  - `rxd` passes a 2-flop synchronizer.
  - A falling edge in idle starts a bit timer. Resample at BAUD_DIV/2 (integer division); if high, abort as a glitch and produce no byte.
  - Otherwise sample 8 data bits LSB-first, one every BAUD_DIV clocks, then the stop bit.
  - Stop bit 0 is a framing error: no byte is delivered, FSM goes to ERR.
  - After the stop sample the receiver waits for `rxd` high before rearming.
- Frame format, all multi-byte fields little-endian:
  - Magic byte 0xA5.
  - 16-bit word count N.
  - N×4 data bytes.
  - 1 checksum byte: XOR of all data bytes.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
  - IDLE: byte 0xA5 → LEN0; any other byte ignored.
  - LEN0: latch low byte → LEN1.
  - LEN1: latch high byte. N=0 or N>MAX_WORDS → ERR; else clear word index and checksum → DATA.
  - DATA:
    - Shift each byte into the word register: byte k of the word occupies bits [8k+7:8k].
    - XOR each byte into the checksum.
    - On the 4th byte: pulse `mem_we` with `mem_addr`=index and `mem_data`=assembled word, then increment the index.
    - After word N-1 → CSUM.
  - CSUM: received byte equals checksum → DONE; else → ERR.
  - DONE: `done`=1, `hold`=0. All further bytes ignored until `reset`.
  - ERR: `error`=1, `hold`=1. A received 0xA5 clears `error` and goes to LEN0; other bytes ignored.
- RAM already written before an ERR keeps its contents; the core stays held.
- The word index is 16 bits, zero-extended onto `mem_addr`; it never wraps because N≤MAX_WORDS.

## Timing

- Byte delivery:
  - Let cycle S be the stop-bit sample cycle.
  - The byte is presented to the FSM at S+1.
  - For the 4th byte of a word, `mem_we` is high during S+2 only, with `mem_addr`/`mem_data` stable in that cycle.
- `mem_addr`/`mem_data` hold their last values when `mem_we`=0.
- `done` rises and `hold` falls at S+2 of the checksum byte; both are registered outputs.
- `error` rises at S+2 of the offending byte, or one cycle after the framing-error sample.
- Back-to-back bytes with no idle gap beyond the stop bit must be accepted: FSM consumption takes 1 cycle, well inside one bit time.
- `reset` asserted mid-frame: outputs return to reset values immediately and asynchronously. A byte already in progress on `rxd` is discarded; its stop bit is not misread as a start edge, because rearming requires `rxd` high.
- `mem_we` is never asserted while `reset` is high or in the cycle it deasserts.

## Test plan

All scenarios use `BAUD_DIV`=4.

- **Single word:** send A5 01 00 78 56 34 12 08. Expect one `mem_we` pulse with `mem_addr`=0 and `mem_data`=0x12345678, then `done`=1, `hold`=0, `error`=0.
- **Two words back-to-back:** N=2, data 0xDEADBEEF then 0x00000001, checksum 0x23. Expect writes at addresses 0 and 1 with those words, then `done`=1.
- **Bad checksum:** single-word frame with checksum 0x09. Expect one write to address 0, then `error`=1 and `hold`=1. Resending the correct frame clears `error` and sets `done`.
- **Bad length and framing:**
  - Length 0x0000 → `error`=1 with no `mem_we`.
  - Length 0x0401 with `MAX_WORDS`=1024 → `error`=1.
  - A byte with stop bit 0 → `error`=1.
- **Glitch and junk:**
  - A 1-clock low pulse on `rxd` in IDLE produces no byte.
  - Bytes 0x00 0xFF before A5 are ignored; the subsequent valid frame loads normally.
- **Reset mid-frame:** assert `reset` during the third data byte. Expect `hold`=1, `mem_we`=0, `done`=0 and `error`=0 immediately. A full valid frame after release loads from address 0.
